// File: rtl/uart_read.sv
// ---------------------------------------------------------------------------
// uart_read -- 8N1 UART receiver with 16x oversampling and a one-deep
// output register.
//
// Ports:
//   clk        system clock, everything on the rising edge
//   reset      synchronous active-high reset
//   Serial_in  asynchronous serial line, idle high
//   rd         read acknowledge; consumes the held byte
//   RX_data    last correctly received byte
//   rx_valid   RX_data holds an unread byte
//   frame_err  sticky: last frame had a low stop bit
//   overrun    sticky: a good byte was dropped because the held byte was unread
//
// Parameters:
//   baudrate   line bit rate in bit/s
//   freq       clk frequency in Hz; oversample divisor is freq/(baudrate*16)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_read #(
  parameter int baudrate = 9600,
  parameter int freq     = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Serial_in,
  input  logic       rd,
  output logic [7:0] RX_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV = freq / (baudrate * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Two-flop synchronizer; resets to the idle (high) line level so a reset
  // never looks like a start edge.
  logic [1:0] sync_q;
  logic       s_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], Serial_in};
    end
  end

  assign s_in = sync_q[1];

  // Free-running 16x oversample tick.
  logic [CW-1:0] div_q;
  logic          tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  state_t     state_q;
  logic [3:0] tcnt_q;
  logic [2:0] bcnt_q;
  logic [7:0] shift_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       frame_err_q;
  logic       overrun_q;

  // The stop bit is sampled on the 16th tick of the STOP state; a high
  // stop bit means the shift register holds a good byte.
  logic stop_sample;
  logic accept;

  assign stop_sample = tick && (state_q == S_STOP) && (tcnt_q == 4'd15);
  assign accept      = stop_sample && s_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tcnt_q      <= 4'd0;
      bcnt_q      <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // Output register and handshake.
      if (accept) begin
        frame_err_q <= 1'b0;
        if (!rx_valid_q || rd) begin
          // A read in the same cycle frees the slot for the new byte.
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else begin
        if (stop_sample) begin
          frame_err_q <= 1'b1;
        end
        if (rd && rx_valid_q) begin
          rx_valid_q <= 1'b0;
          overrun_q  <= 1'b0;
        end
      end

      // Frame FSM, advancing only on oversample ticks.
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (!s_in) begin
              state_q <= S_START;
              tcnt_q  <= 4'd0;
            end
          end

          S_START: begin
            // Re-check the line half a bit in to reject short glitches.
            if (tcnt_q == 4'd7) begin
              tcnt_q <= 4'd0;
              if (!s_in) begin
                state_q <= S_DATA;
                bcnt_q  <= 3'd0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              tcnt_q <= tcnt_q + 4'd1;
            end
          end

          S_DATA: begin
            if (tcnt_q == 4'd15) begin
              tcnt_q  <= 4'd0;
              shift_q <= {s_in, shift_q[7:1]};
              if (bcnt_q == 3'd7) begin
                state_q <= S_STOP;
              end else begin
                bcnt_q <= bcnt_q + 3'd1;
              end
            end else begin
              tcnt_q <= tcnt_q + 4'd1;
            end
          end

          S_STOP: begin
            if (tcnt_q == 4'd15) begin
              tcnt_q  <= 4'd0;
              state_q <= s_in ? S_IDLE : S_BREAK;
            end else begin
              tcnt_q <= tcnt_q + 4'd1;
            end
          end

          S_BREAK: begin
            // A line held low after a bad stop bit must not start new frames.
            if (s_in) begin
              state_q <= S_IDLE;
            end
          end

          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign RX_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_read.sv
// ---------------------------------------------------------------------------
// tb_uart_read -- self-checking bench for uart_read (DIV = 10, 160 clk/bit).
// Expected bytes are queued when a good frame is driven and popped when the
// byte is read out of the DUT.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_read;

  localparam int FREQ = 1600000;
  localparam int BAUD = 10000;
  localparam int BIT  = 160;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial;
  logic       rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int acc_k  = 0;

  logic [7:0] exp_q[$];
  bit         model_valid = 1'b0;
  bit         model_overrun = 1'b0;

  uart_read #(.baudrate(BAUD), .freq(FREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .Serial_in (serial),
    .rd        (rd),
    .RX_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start frames on a fixed phase of the DUT's tick counter.
  task automatic align();
    do @(negedge clk); while (cyc % 10 != 0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    serial = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      serial = b[i];
      idle(BIT);
    end
    serial = stop_bit;
    idle(BIT);
    serial = 1'b1;
  endtask

  // Reference model of the one-deep holding register.
  task automatic sent_good(input logic [7:0] b);
    if (!model_valid) begin
      exp_q.push_back(b);
      model_valid = 1'b1;
    end else begin
      model_overrun = 1'b1;
    end
  endtask

  task automatic read_byte(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while (!rx_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_valid"}, rx_valid, 1);
    check_val({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val({tag, "_data"}, rx_data, e);
    end
    check_val({tag, "_overrun_before_rd"}, overrun, model_overrun);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    model_valid   = 1'b0;
    model_overrun = 1'b0;
    check_val({tag, "_valid_after_rd"}, rx_valid, 0);
    check_val({tag, "_overrun_after_rd"}, overrun, 0);
    $display("read %s: RX_data=0x%02h", tag, rx_data);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;

    serial = 1'b1;
    rd     = 1'b0;
    reset  = 1'b1;
    idle(3);
    reset  = 1'b0;
    idle(1);
    check_val("rst_data", rx_data, 8'h00);
    check_val("rst_valid", rx_valid, 0);
    check_val("rst_frame_err", frame_err, 0);
    check_val("rst_overrun", overrun, 0);

    // Good frame 0xA5; measure acceptance latency from the start edge.
    align();
    c0 = cyc;
    sent_good(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        n = 0;
        while (!rx_valid && n < 2000) begin
          @(negedge clk);
          n++;
        end
        acc_k = cyc - c0;
      end
    join
    check_val("t1_valid_seen", rx_valid, 1);
    check_val("t1_latency_mid_stop", (acc_k >= 1521 && acc_k <= 1535), 1);
    check_val("t1_frame_err", frame_err, 0);
    $display("frame 0xA5: accepted %0d clk after start edge", acc_k);
    read_byte("t1");

    // 40-clk glitch must be rejected without flags, then frame 0x3C.
    align();
    serial = 1'b0;
    idle(40);
    serial = 1'b1;
    idle(400);
    check_val("t2_glitch_valid", rx_valid, 0);
    check_val("t2_glitch_frame_err", frame_err, 0);
    check_val("t2_glitch_overrun", overrun, 0);
    $display("glitch: rx_valid=%0b frame_err=%0b", rx_valid, frame_err);
    align();
    sent_good(8'h3C);
    send_frame(8'h3C, 1'b1);
    read_byte("t2");

    // Bad stop bit followed by a long low hold.
    align();
    send_frame(8'h55, 1'b0);
    serial = 1'b0;
    idle(500);
    serial = 1'b1;
    idle(20);
    check_val("t3_frame_err", frame_err, 1);
    check_val("t3_valid", rx_valid, 0);
    idle(1700);
    check_val("t3_no_retrigger_valid", rx_valid, 0);
    check_val("t3_frame_err_sticky", frame_err, 1);
    $display("break: frame_err=%0b rx_valid=%0b", frame_err, rx_valid);
    align();
    sent_good(8'h12);
    send_frame(8'h12, 1'b1);
    check_val("t3_frame_err_cleared", frame_err, 0);
    read_byte("t3");

    // Back-to-back frames without a read: second byte is dropped.
    align();
    sent_good(8'h11);
    send_frame(8'h11, 1'b1);
    sent_good(8'h22);
    send_frame(8'h22, 1'b1);
    check_val("t4_overrun", overrun, 1);
    check_val("t4_data_kept", rx_data, 8'h11);
    read_byte("t4");

    // Read exactly on the acceptance cycle of the second byte.
    align();
    sent_good(8'h11);
    send_frame(8'h11, 1'b1);
    check_val("t5_first_valid", rx_valid, 1);
    check_val("t5_first_data", rx_data, 8'h11);
    c0 = cyc;
    fork
      send_frame(8'h22, 1'b1);
      begin
        while (cyc < c0 + acc_k - 1) @(negedge clk);
        check_val("t5_pre_accept_valid", rx_valid, 1);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    // The read consumed 0x11 and the new byte took its place.
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    model_valid = 1'b0;
    sent_good(8'h22);
    check_val("t5_valid_kept", rx_valid, 1);
    check_val("t5_overrun", overrun, 0);
    read_byte("t5");

    // Reset in the middle of data bit 4.
    align();
    serial = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      serial = (8'h9B >> i) & 8'h01;
      idle(BIT);
    end
    serial = 1'b1;
    idle(BIT / 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    model_valid   = 1'b0;
    model_overrun = 1'b0;
    check_val("t6_rst_data", rx_data, 8'h00);
    check_val("t6_rst_valid", rx_valid, 0);
    check_val("t6_rst_frame_err", frame_err, 0);
    check_val("t6_rst_overrun", overrun, 0);
    idle(2000);
    check_val("t6_no_partial_valid", rx_valid, 0);
    check_val("t6_no_partial_frame_err", frame_err, 0);
    $display("mid-frame reset: rx_valid=%0b RX_data=0x%02h", rx_valid, rx_data);
    align();
    sent_good(8'hF0);
    send_frame(8'hF0, 1'b1);
    read_byte("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
